// File: rtl/p2s_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : p2s_serializer
//  Description : Pops words one at a time from an upstream FIFO + pipeline,
//                waits the fixed pop-to-data latency, captures the word and
//                shifts it out one bit per accepted beat on a valid/ready
//                serial link, marking first/last beats with sof/eof and
//                counting completed words.
//  Optional    : `define P2S_SERIALIZER_PARITY_EN appends an even-parity beat
//                (XOR of the data bits) after the last data bit; eof then
//                marks the parity beat.
//  Ports       : clk, rstn (async, active-low)
//                en          - permits new pops
//                fifo_empty  - upstream empty flag
//                fifo_pop    - one-cycle pop strobe
//                fifo_data   - pipelined pop data (valid POP_LATENCY edges
//                              after the pop is sampled)
//                ser_valid / ser_ready / ser_data - serial link
//                ser_sof / ser_eof - first / last beat of a word
//                busy        - FSM not in IDLE
//                word_count  - words whose last beat was accepted (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module p2s_serializer #(
    parameter int DATA_WIDTH  = 11,
    parameter int POP_LATENCY = 3,
    parameter int MSB_FIRST   = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_data,
    output logic                  ser_sof,
    output logic                  ser_eof,
    output logic                  busy,
    output logic [15:0]           word_count
);

`ifdef P2S_SERIALIZER_PARITY_EN
    localparam int c_BEATS = DATA_WIDTH + 1;
`else
    localparam int c_BEATS = DATA_WIDTH;
`endif
    localparam int c_IDX_W = $clog2(c_BEATS);
    localparam int c_LAT_W = (POP_LATENCY < 2) ? 1 : $clog2(POP_LATENCY + 1);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_BEATS - 1);
    localparam logic [c_LAT_W-1:0] c_LAT  = c_LAT_W'(POP_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POP   = 2'd1,
        S_WAIT  = 2'd2,
        S_SHIFT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_IDX_W-1:0]    r_idx;
    logic [c_LAT_W-1:0]    r_lat;
    logic [15:0]           r_count;

    logic w_accept;
    logic w_last;
    logic w_can_pop;
    logic w_lat_done;
    logic w_data_bit;
    logic w_out_bit;

    assign w_accept   = (r_state == S_SHIFT) && ser_ready;
    assign w_last     = (r_idx == c_LAST);
    assign w_can_pop  = en && !fifo_empty;
    assign w_lat_done = (r_lat == c_LAT);
    assign w_data_bit = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1] : r_shift[0];

`ifdef P2S_SERIALIZER_PARITY_EN
    logic r_parity;
    // The parity beat sits at index DATA_WIDTH, after every data bit.
    assign w_out_bit = (r_idx == c_IDX_W'(DATA_WIDTH)) ? r_parity : w_data_bit;
`else
    assign w_out_bit = w_data_bit;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_can_pop) w_next = S_POP;
            S_POP:   w_next = S_WAIT;
            S_WAIT:  if (w_lat_done) w_next = S_SHIFT;
            S_SHIFT: begin
                // Going straight to POP avoids an IDLE bubble between words.
                if (w_accept && w_last) w_next = w_can_pop ? S_POP : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Datapath: latency counter, shift register, bit index, word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_lat   <= '0;
            r_count <= '0;
`ifdef P2S_SERIALIZER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                // Leaving POP is edge E0; the counter then holds the number
                // of edges elapsed since E0.
                S_POP: r_lat <= c_LAT_W'(1);
                S_WAIT: begin
                    if (w_lat_done) begin
                        r_shift <= fifo_data;
                        r_idx   <= '0;
`ifdef P2S_SERIALIZER_PARITY_EN
                        r_parity <= ^fifo_data;
`endif
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (w_accept) begin
                        if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                        else                r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                        if (w_last) begin
                            r_idx   <= '0;
                            r_count <= r_count + 16'd1;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from registered state only.
    assign fifo_pop   = (r_state == S_POP);
    assign busy       = (r_state != S_IDLE);
    assign ser_valid  = (r_state == S_SHIFT);
    assign ser_data   = (r_state == S_SHIFT) && w_out_bit;
    assign ser_sof    = (r_state == S_SHIFT) && (r_idx == '0);
    assign ser_eof    = (r_state == S_SHIFT) && w_last;
    assign word_count = r_count;

endmodule
`default_nettype wire
